// File: rtl/issue_scheduler_if.sv
// rtl/issue_scheduler_if.sv - issue buffer head / scheduler decision bundle
interface issue_scheduler_if #(
    parameter int TYPE_W = 10
);
    logic              h0_valid;
    logic              h1_valid;
    logic [TYPE_W-1:0] h0_type;
    logic [TYPE_W-1:0] h1_type;
    logic [4:0]        h0_rs1;
    logic [4:0]        h0_rs2;
    logic [4:0]        h1_rs1;
    logic [4:0]        h1_rs2;
    logic [4:0]        h0_rd;
    logic [4:0]        h1_rd;
    logic              h0_we;
    logic              h1_we;
    logic              h0_load;
    logic              h1_load;
    logic              flush_BR;
    logic              stall_DCache;
    logic              stall_div;
    logic              pipe_empty;
    logic              serial_commit;
    logic [1:0]        issue_pop;
    logic              issue_v0;
    logic              issue_v1;
    logic              serial_busy;
    logic [31:0]       dual_cnt;
    logic [31:0]       bubble_cnt;

    modport master (
        output h0_valid, h1_valid, h0_type, h1_type, h0_rs1, h0_rs2, h1_rs1, h1_rs2,
               h0_rd, h1_rd, h0_we, h1_we, h0_load, h1_load,
               flush_BR, stall_DCache, stall_div, pipe_empty, serial_commit,
        input  issue_pop, issue_v0, issue_v1, serial_busy, dual_cnt, bubble_cnt
    );

    modport slave (
        input  h0_valid, h1_valid, h0_type, h1_type, h0_rs1, h0_rs2, h1_rs1, h1_rs2,
               h0_rd, h1_rd, h0_we, h1_we, h0_load, h1_load,
               flush_BR, stall_DCache, stall_div, pipe_empty, serial_commit,
        output issue_pop, issue_v0, issue_v1, serial_busy, dual_cnt, bubble_cnt
    );
endinterface

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - dual-issue decision with hazard checks and serialization drain FSM
module issue_scheduler #(
    parameter int TYPE_W  = 10,
    parameter bit DUAL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rstn,
    issue_scheduler_if.slave bus
);
    typedef enum logic [1:0] {RUN, DRAIN, SOLO, WAIT} state_t;

    state_t      state_q, state_d;
    logic        load_pending_q, load_pending_d;
    logic [4:0]  load_rd_q, load_rd_d;
    logic [31:0] dual_cnt_q, dual_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    logic v0, v1, bubble, stall;
    logic ser0, ser1, alu0, alu1, luse0, luse1, raw, waw, dual_ok;

    function automatic logic is_ser(input logic [TYPE_W-1:0] t);
        return t[4] | t[5] | t[7] | t[8];
    endfunction

    function automatic logic is_alu(input logic [TYPE_W-1:0] t);
        return t == TYPE_W'(1);
    endfunction

    assign stall = bus.stall_DCache | bus.stall_div;
    assign ser0  = is_ser(bus.h0_type);
    assign ser1  = is_ser(bus.h1_type);
    assign alu0  = is_alu(bus.h0_type);
    assign alu1  = is_alu(bus.h1_type);
    assign luse0 = load_pending_q && (load_rd_q != 5'd0) &&
                   (bus.h0_rs1 == load_rd_q || bus.h0_rs2 == load_rd_q);
    assign luse1 = load_pending_q && (load_rd_q != 5'd0) &&
                   (bus.h1_rs1 == load_rd_q || bus.h1_rs2 == load_rd_q);
    assign raw   = bus.h0_we && (bus.h0_rd != 5'd0) &&
                   (bus.h1_rs1 == bus.h0_rd || bus.h1_rs2 == bus.h0_rd);
    assign waw   = bus.h0_we && bus.h1_we && (bus.h0_rd != 5'd0) && (bus.h0_rd == bus.h1_rd);
    // Pipe A only runs simple ALU ops, so a pair needs at least one ALU
    assign dual_ok = DUAL_EN && bus.h1_valid && !ser1 && !luse1 &&
                     (alu0 || alu1) && !raw && !waw;

    always_comb begin
        v0      = 1'b0;
        v1      = 1'b0;
        bubble  = 1'b0;
        state_d = state_q;
        if (!rstn) begin
            state_d = RUN;
        end else if (bus.flush_BR) begin
            state_d = RUN;
        end else if (!stall) begin
            unique case (state_q)
                RUN: begin
                    if (bus.h0_valid) begin
                        if (ser0) begin
                            state_d = DRAIN;
                        end else if (luse0) begin
                            bubble = 1'b1;
                        end else begin
                            v0 = 1'b1;
                            v1 = dual_ok;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.pipe_empty) state_d = SOLO;
                end
                SOLO: begin
                    if (bus.h0_valid) begin
                        v0      = 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.serial_commit) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        load_pending_d = load_pending_q;
        load_rd_d      = load_rd_q;
        dual_cnt_d     = dual_cnt_q;
        bubble_cnt_d   = bubble_cnt_q;
        if (bus.flush_BR) begin
            load_pending_d = 1'b0;
        end else if (!stall) begin
            load_pending_d = (v0 & bus.h0_load) | (v1 & bus.h1_load);
            if (v0 && bus.h0_load) begin
                load_rd_d = bus.h0_rd;
            end else if (v1 && bus.h1_load) begin
                load_rd_d = bus.h1_rd;
            end
        end
        if (v0 && v1) dual_cnt_d = dual_cnt_q + 32'd1;
        if (bubble) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= RUN;
            load_pending_q <= 1'b0;
            load_rd_q      <= 5'd0;
            dual_cnt_q     <= 32'd0;
            bubble_cnt_q   <= 32'd0;
        end else begin
            state_q        <= state_d;
            load_pending_q <= load_pending_d;
            load_rd_q      <= load_rd_d;
            dual_cnt_q     <= dual_cnt_d;
            bubble_cnt_q   <= bubble_cnt_d;
        end
    end

    assign bus.issue_v0    = v0;
    assign bus.issue_v1    = v1;
    assign bus.issue_pop   = {1'b0, v0} + {1'b0, v1};
    assign bus.serial_busy = (state_q != RUN);
    assign bus.dual_cnt    = dual_cnt_q;
    assign bus.bubble_cnt  = bubble_cnt_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - directed checks of issue_scheduler decisions, FSM and counters
module tb_issue_scheduler;
    localparam logic [9:0] T_ALU   = 10'h001;
    localparam logic [9:0] T_MUL   = 10'h004;
    localparam logic [9:0] T_DIV   = 10'h008;
    localparam logic [9:0] T_CSR   = 10'h010;
    localparam logic [9:0] T_MEM   = 10'h040;
    localparam logic [9:0] T_CACOP = 10'h080;

    logic clk = 1'b0;
    logic rstn;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    issue_scheduler_if #(.TYPE_W(10)) bus0 ();
    issue_scheduler_if #(.TYPE_W(10)) bus1 ();

    issue_scheduler #(.TYPE_W(10), .DUAL_EN(1'b1)) dut (.clk(clk), .rstn(rstn), .bus(bus0));
    issue_scheduler #(.TYPE_W(10), .DUAL_EN(1'b0)) dut_single (.clk(clk), .rstn(rstn), .bus(bus1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_h0(input logic v, input logic [9:0] t, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic we,
                          input logic ld);
        bus0.h0_valid = v;  bus0.h0_type = t;  bus0.h0_rs1 = rs1; bus0.h0_rs2 = rs2;
        bus0.h0_rd    = rd; bus0.h0_we   = we; bus0.h0_load = ld;
    endtask

    task automatic set_h1(input logic v, input logic [9:0] t, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic we,
                          input logic ld);
        bus0.h1_valid = v;  bus0.h1_type = t;  bus0.h1_rs1 = rs1; bus0.h1_rs2 = rs2;
        bus0.h1_rd    = rd; bus0.h1_we   = we; bus0.h1_load = ld;
    endtask

    task automatic chk_issue(input string tag, input logic [1:0] pop, input logic v0,
                             input logic v1);
        #1;
        check({tag, ".pop"}, 32'(bus0.issue_pop), 32'(pop));
        check({tag, ".v0"},  32'(bus0.issue_v0),  32'(v0));
        check({tag, ".v1"},  32'(bus0.issue_v1),  32'(v1));
    endtask

    initial begin
        rstn = 1'b0;
        set_h0(1'b1, T_ALU, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        set_h1(1'b0, T_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        bus0.flush_BR = 1'b0; bus0.stall_DCache = 1'b0; bus0.stall_div = 1'b0;
        bus0.pipe_empty = 1'b0; bus0.serial_commit = 1'b0;
        bus1.h0_valid = 1'b0; bus1.h1_valid = 1'b0; bus1.h0_type = T_ALU; bus1.h1_type = T_ALU;
        bus1.h0_rs1 = 5'd0; bus1.h0_rs2 = 5'd0; bus1.h1_rs1 = 5'd0; bus1.h1_rs2 = 5'd0;
        bus1.h0_rd = 5'd1; bus1.h1_rd = 5'd2; bus1.h0_we = 1'b1; bus1.h1_we = 1'b1;
        bus1.h0_load = 1'b0; bus1.h1_load = 1'b0;
        bus1.flush_BR = 1'b0; bus1.stall_DCache = 1'b0; bus1.stall_div = 1'b0;
        bus1.pipe_empty = 1'b0; bus1.serial_commit = 1'b0;

        step(); step();
        chk_issue("reset", 2'd0, 1'b0, 1'b0);
        check("reset.busy",   32'(bus0.serial_busy), 32'd0);
        check("reset.dual",   bus0.dual_cnt,   32'd0);
        check("reset.bubble", bus0.bubble_cnt, 32'd0);
        rstn = 1'b1;

        // ALU + mul, independent
        set_h1(1'b1, T_MUL, 5'd6, 5'd0, 5'd8, 1'b1, 1'b0);
        chk_issue("pair_alu_mul", 2'd2, 1'b1, 1'b1);
        step();
        check("dual_cnt1", bus0.dual_cnt, 32'd1);

        // intra-pair RAW, then the dependent one alone
        set_h1(1'b1, T_ALU, 5'd3, 5'd5, 5'd9, 1'b1, 1'b0);
        chk_issue("raw", 2'd1, 1'b1, 1'b0);
        step();
        set_h0(1'b1, T_ALU, 5'd3, 5'd5, 5'd9, 1'b1, 1'b0);
        set_h1(1'b0, T_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk_issue("raw_next", 2'd1, 1'b1, 1'b0);
        set_h0(1'b1, T_ALU, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        set_h1(1'b1, T_ALU, 5'd4, 5'd4, 5'd3, 1'b1, 1'b0);
        chk_issue("waw", 2'd1, 1'b1, 1'b0);
        step();

        // load rd=7 then consumer
        set_h0(1'b1, T_MEM, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
        set_h1(1'b0, T_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk_issue("load7", 2'd1, 1'b1, 1'b0);
        step();
        set_h0(1'b1, T_ALU, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        set_h1(1'b1, T_ALU, 5'd7, 5'd0, 5'd4, 1'b1, 1'b0);
        chk_issue("luse_h1", 2'd1, 1'b1, 1'b0);
        set_h0(1'b1, T_ALU, 5'd7, 5'd2, 5'd3, 1'b1, 1'b0);
        set_h1(1'b0, T_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk_issue("luse_h0", 2'd0, 1'b0, 1'b0);
        step();
        check("bubble_cnt1", bus0.bubble_cnt, 32'd1);
        chk_issue("after_bubble", 2'd1, 1'b1, 1'b0);
        step();
        set_h0(1'b1, T_MEM, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1);
        chk_issue("load0", 2'd1, 1'b1, 1'b0);
        step();
        set_h0(1'b1, T_ALU, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        chk_issue("load0_use", 2'd1, 1'b1, 1'b0);
        step();
        check("bubble_cnt_hold", bus0.bubble_cnt, 32'd1);

        // stall holds everything
        bus0.stall_DCache = 1'b1;
        chk_issue("stall", 2'd0, 1'b0, 1'b0);
        step();
        bus0.stall_DCache = 1'b0;

        // csr serialization
        set_h0(1'b1, T_CSR, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0);
        set_h1(1'b1, T_ALU, 5'd2, 5'd2, 5'd6, 1'b1, 1'b0);
        chk_issue("csr_run", 2'd0, 1'b0, 1'b0);
        check("csr_run.busy", 32'(bus0.serial_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_issue("drain", 2'd0, 1'b0, 1'b0);
            check("drain.busy", 32'(bus0.serial_busy), 32'd1);
        end
        bus0.pipe_empty = 1'b1;
        chk_issue("drain_empty", 2'd0, 1'b0, 1'b0);
        step();
        chk_issue("solo", 2'd1, 1'b1, 1'b0);
        check("solo.busy", 32'(bus0.serial_busy), 32'd1);
        step();
        set_h0(1'b1, T_ALU, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        set_h1(1'b0, T_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk_issue("wait", 2'd0, 1'b0, 1'b0);
        check("wait.busy", 32'(bus0.serial_busy), 32'd1);
        step();
        bus0.serial_commit = 1'b1;
        chk_issue("wait_commit", 2'd0, 1'b0, 1'b0);
        step();
        bus0.serial_commit = 1'b0;
        check("run_again.busy", 32'(bus0.serial_busy), 32'd0);
        chk_issue("run_again", 2'd1, 1'b1, 1'b0);
        step();

        // cacop load into WAIT, then flush with stall
        set_h0(1'b1, T_CACOP, 5'd1, 5'd0, 5'd9, 1'b1, 1'b1);
        step();
        step();
        chk_issue("cacop_solo", 2'd1, 1'b1, 1'b0);
        step();
        check("cacop_wait.busy", 32'(bus0.serial_busy), 32'd1);
        bus0.stall_div = 1'b1;
        bus0.flush_BR  = 1'b1;
        chk_issue("flush_stall", 2'd0, 1'b0, 1'b0);
        step();
        bus0.stall_div = 1'b0;
        bus0.flush_BR  = 1'b0;
        check("flush.busy", 32'(bus0.serial_busy), 32'd0);
        set_h0(1'b1, T_ALU, 5'd9, 5'd2, 5'd3, 1'b1, 1'b0);
        chk_issue("flush_no_luse", 2'd1, 1'b1, 1'b0);
        step();
        check("flush.bubble", bus0.bubble_cnt, 32'd1);

        // two non-ALU, then an independent ALU pair on both builds
        set_h0(1'b1, T_MUL, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        set_h1(1'b1, T_DIV, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0);
        chk_issue("mul_div", 2'd1, 1'b1, 1'b0);
        step();
        set_h0(1'b1, T_ALU, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
        set_h1(1'b1, T_ALU, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
        bus1.h0_valid = 1'b1;
        bus1.h1_valid = 1'b1;
        chk_issue("alu_alu", 2'd2, 1'b1, 1'b1);
        check("single.pop", 32'(bus1.issue_pop), 32'd1);
        check("single.v1",  32'(bus1.issue_v1),  32'd0);
        step();
        check("dual_cnt2", bus0.dual_cnt, 32'd2);
        check("single.dual", bus1.dual_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Decides each cycle how many instructions leave the head of the issue buffer (0, 1 or 2) and drives the valid bits consumed by the Issue→EXE pipeline register.
- Pipe A executes only simple-ALU instructions. Pipe B executes everything else.
- Enforces intra-pair RAW/WAW hazards, load-use bubbles, one non-ALU per pair, and full serialization of CSR/ERTN/CACOP/barrier instructions via a drain FSM.

Parameters:
- TYPE_W, 10, width of one-hot instruction class: bit0 ALU, bit1 branch, bit2 mul, bit3 div, bit4 csr, bit5 ertn, bit6 mem, bit7 cacop, bit8 barrier, bit9 other.
- DUAL_EN, 1, 0 forces single issue.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, active-low
- h0_valid / h1_valid  in  1  buffer head entry 0/1 present
- h0_type / h1_type  in  TYPE_W  class
- h0_rs1, h0_rs2, h1_rs1, h1_rs2  in  5  source registers
- h0_rd / h1_rd  in  5  destination register
- h0_we / h1_we  in  1  register-file write enable
- h0_load / h1_load  in  1  instruction is a load
- flush_BR  in  1  branch/exception flush
- stall_DCache, stall_div  in  1  backend stalls
- pipe_empty  in  1  EX..WB hold no valid instruction
- serial_commit  in  1  serialized instruction retired at WB
- issue_pop  out  2  entries consumed this cycle
- issue_v0 / issue_v1  out  1  head0/head1 issued; the Issue→EXE register takes these as i_set1/i_set2 valid
- serial_busy  out  1  state != RUN
- dual_cnt  out  32  dual-issue cycle count
- bubble_cnt  out  32  load-use bubble count

Behaviour:
- Clock and reset: one clock `clk`. Reset `rstn` is asynchronous and active-low.
- Reset values: state=RUN, load_pending=0, load_rd=0, dual_cnt=0, bubble_cnt=0. issue_pop=0 and issue_v0=issue_v1=0 while rstn=0.
- Decision path: issue_pop, issue_v0 and issue_v1 are combinational from state, registers and inputs. All other state is registered.
- Definitions:
  - ser(t) = t[4]|t[5]|t[7]|t[8]
  - alu(t) = (t==10'h001)
  - luse(x) = load_pending & load_rd!=0 & (x_rs1==load_rd | x_rs2==load_rd)
  - raw = h0_we & h0_rd!=0 & (h1_rs1==h0_rd | h1_rs2==h0_rd)
  - waw = h0_we & h1_we & h0_rd!=0 & h0_rd==h1_rd
- Priority, any state:
  - flush_BR: issue 0, state→RUN, load_pending→0. Flush beats stall.
  - Otherwise, stall (stall_DCache|stall_div): issue 0, all registers hold.
- RUN:
  - !h0_valid → issue 0.
  - ser(h0) → issue 0, →DRAIN.
  - luse(h0) → issue 0, bubble_cnt+1.
  - Otherwise issue h0 (v0=1). Also issue h1 (v1=1, pop=2) iff all hold: DUAL_EN, h1_valid, !ser(h1), !luse(h1), (alu(h0)|alu(h1)), !raw, !waw. Otherwise pop=1.
- DRAIN: issue 0; pipe_empty → SOLO.
- SOLO: issue h0 alone (pop=1, v0=1) → WAIT. If h0_valid=0 in SOLO, remain in SOLO (cannot happen legally).
- WAIT: issue 0; serial_commit → RUN.
- Load tracking, on a non-stalled, non-flushed cycle:
  - load_pending ← OR of (issued & load) over issued entries.
  - load_rd ← rd of that load. At most one issued load exists, since mem is non-ALU.
  - A cycle with 0 issued clears load_pending.
- Counters:
  - dual_cnt increments when pop==2.
  - bubble_cnt increments on a luse(h0) bubble.
  - Both wrap modulo 2^32 and are unaffected by flush.
- Reset asserted mid-DRAIN/WAIT returns to RUN immediately (asynchronous).

Test Plan:
1. Reset then h0 = ALU (rd=5), h1 = mul (rs1=6), no hazards → pop=2, v0=v1=1, dual_cnt=1.
2. h0 = ALU rd=5, h1 = ALU rs2=5 → pop=1. Next cycle, h1 as the new h0 → pop≥1.
3. h0 = load rd=7 issued, then h0 = ALU rs1=7 → one bubble (pop=0, bubble_cnt=1), then pop≥1. Repeat with load rd=0 → no bubble.
4. h0 = csr with pipe_empty=0 for 3 cycles → RUN→DRAIN. pop=0 until pipe_empty=1, then SOLO issues pop=1 alone, then WAIT until serial_commit, then RUN; serial_busy=1 throughout DRAIN/SOLO/WAIT.
5. stall_div=1 with flush_BR=1 while in WAIT with load_pending=1 → pop=0, state=RUN, load_pending=0 next cycle.
6. h0 = mul, h1 = div (both non-ALU) → pop=1. With DUAL_EN=0, an ALU/ALU pair → pop=1.
